// File: rtl/tx_envelope_shaper.sv
// TX amplitude stage: programmable gain plus linear key-up/key-down
// envelope ahead of the DAC output corrector.
module tx_envelope_shaper #(
  parameter int in_width  = 16,
  parameter int out_width = 27,
  parameter int ramp_bits = 10
) (
  input  logic                        clk_in,
  input  logic                        reset_n,
  input  logic                        tx_en,
  input  logic [7:0]                  gain,
  input  logic signed [in_width-1:0]  data_in,
  input  logic                        data_in_valid,
  output logic signed [out_width-1:0] data_out,
  output logic                        data_out_valid,
  output logic                        tx_active,
  output logic                        ramp_busy
);

  localparam int P_W  = in_width + 8;
  localparam int E_W  = ramp_bits + 1;
  localparam int PR_W = P_W + E_W;
  localparam int SH   = out_width - in_width - 8;

  localparam logic [E_W-1:0] ENV_FULL = E_W'(1) << ramp_bits;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    ON,
    RAMP_DOWN
  } state_t;

  state_t                 state_q, state_d;
  logic [E_W-1:0]         env_q, env_d;
  logic                   tx_active_q;
  logic                   ramp_busy_q;

  logic signed [P_W-1:0]  p1_q;
  logic [E_W-1:0]         env1_q;
  logic                   v1_q;

  logic signed [out_width-1:0] dout_q;
  logic                        vout_q;

  logic signed [P_W-1:0]  din_x;
  logic signed [P_W-1:0]  gain_x;
  logic signed [P_W-1:0]  p1_d;
  logic signed [PR_W-1:0] p1_x;
  logic signed [PR_W-1:0] env_x;
  logic signed [PR_W-1:0] prod;
  logic signed [P_W-1:0]  p2;
  logic signed [out_width-1:0] p2_ext;
  logic signed [out_width-1:0] dout_d;

  // Envelope step: only on a valid sample, using the current state's rule
  always_comb begin
    env_d = env_q;
    if (data_in_valid) begin
      case (state_q)
        RAMP_UP:   if (env_q != ENV_FULL) env_d = env_q + 1'b1;
        RAMP_DOWN: if (env_q != '0)       env_d = env_q - 1'b1;
        default:   env_d = env_q;
      endcase
    end
  end

  // Next state: tx_en reversals win; ramp ends when env reaches its end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tx_en) state_d = RAMP_UP;
      RAMP_UP: begin
        if (!tx_en)                state_d = RAMP_DOWN;
        else if (env_d == ENV_FULL) state_d = ON;
      end
      ON:        if (!tx_en) state_d = RAMP_DOWN;
      RAMP_DOWN: begin
        if (tx_en)             state_d = RAMP_UP;
        else if (env_d == '0)  state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Control state, envelope and registered status flags
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      env_q       <= '0;
      tx_active_q <= 1'b0;
      ramp_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      env_q       <= env_d;
      tx_active_q <= (state_d != IDLE);
      ramp_busy_q <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
    end
  end

  // Stage 1 operands: sign-extend sample, zero-extend gain
  always_comb begin
    din_x  = P_W'(data_in);
    gain_x = P_W'({1'b0, gain});
    p1_d   = din_x * gain_x;
  end

  // Stage 1: gained sample with the envelope weight it was taken at
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      p1_q   <= '0;
      env1_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= data_in_valid;
      if (data_in_valid) begin
        p1_q   <= p1_d;
        env1_q <= env_q;
      end
    end
  end

  // Stage 2 math: envelope weighting with floor shift, then scale up
  always_comb begin
    p1_x   = PR_W'(p1_q);
    env_x  = PR_W'(env1_q);
    prod   = p1_x * env_x;
    p2     = P_W'(prod >>> ramp_bits);
    p2_ext = out_width'(p2);
    dout_d = p2_ext <<< SH;
  end

  // Stage 2: output register, held between valid samples
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
      vout_q <= 1'b0;
    end else begin
      vout_q <= v1_q;
      if (v1_q) dout_q <= dout_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = vout_q;
  assign tx_active      = tx_active_q;
  assign ramp_busy      = ramp_busy_q;

endmodule

// File: doc/tx_envelope_shaper.md
# tx_envelope_shaper

Transmit-path amplitude stage placed directly upstream of the DAC output corrector. Takes signed baseband/IF samples, applies a programmable digital gain and a linear ramp-up/ramp-down envelope on TX key-up/key-down to suppress key clicks. Delivers a 27-bit signed full-scale word that the corrector rounds to the 14-bit offset-binary DAC code.

## Interface
- in_width, 16: input sample width, signed.
- out_width, 27: output sample width, signed; must equal the corrector's input width.
- ramp_bits, 10: envelope resolution R; ramp length is 2^R input samples.
- clk_in  in  1  sample-domain clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tx_en  in  1  transmit request, level, synchronous to clk_in.
- gain  in  8  unsigned linear gain, 0..255.
- data_in  in  in_width  signed sample.
- data_in_valid  in  1  one-cycle strobe qualifying data_in.
- data_out  out  out_width  signed shaped sample, registered.
- data_out_valid  out  1  one-cycle strobe qualifying data_out.
- tx_active  out  1  high whenever state is not IDLE.
- ramp_busy  out  1  high in RAMP_UP or RAMP_DOWN.

## Operation
- Envelope register env: R+1 bits unsigned, range 0..2^R.
- States and transitions (tx_en sampled every clock; env changes only on data_in_valid):
  - IDLE: env=0. tx_en=1 -> RAMP_UP next edge.
  - RAMP_UP: on each valid, env+1. The edge that writes env=2^R also enters ON. tx_en=0 -> RAMP_DOWN from current env.
  - ON: env=2^R. tx_en=0 -> RAMP_DOWN.
  - RAMP_DOWN: on each valid, env-1. The edge that writes env=0 also enters IDLE. tx_en=1 -> RAMP_UP from current env.
- A state change caused by tx_en and an env update on the same edge: the env update uses the old state's rule; the new state takes effect the next cycle.
- Each sample is weighted by the env value present in the cycle its data_in_valid is high, before that cycle's update.
- Arithmetic per sample:
  - p1 = data_in * {0,gain}, 24-bit signed.
  - p2 = (p1 * env) >>> R, arithmetic shift (floor).
  - data_out = p2 <<< (out_width - in_width - 8), sign-extended to out_width.
- The result always fits: worst case -32768*255*8 = -66846720 > -2^26. No saturation logic.
- gain is sampled with the sample in pipeline stage 1; changing gain mid-stream affects only later samples.
- data_out_valid follows every data_in_valid in all states, including IDLE, where data_out=0. This keeps the DAC stream continuous.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, env=0, pipeline registers=0, data_out=0, data_out_valid=0, tx_active=0, ramp_busy=0.
- Latency: exactly 2 clk_in cycles from data_in_valid to data_out_valid.
  - Stage 1 registers p1, env and valid.
  - Stage 2 registers data_out and valid.
- Back-to-back valids, one per clock, are supported at full throughput.
- tx_active and ramp_busy are registered from the state and change on the edge where the state changes.
- Reset mid-ramp: all outputs return to reset values immediately. In-flight samples are discarded, with no valid emitted.

## Test plan
- Reset check: assert reset_n=0 with random inputs -> all outputs 0. After release with tx_en=0, data_in=1000 and valid every cycle -> data_out=0 with valid, 2 cycles after each input; tx_active=0.
- Ramp up: R=10, gain=128, data_in=16384 constant, tx_en raised -> successive outputs 0, 16384, 32768, … (step 16384). After 1024 valids, state is ON, data_out=16777216 steady, ramp_busy=0.
- Ramp down: from ON, drop tx_en -> outputs decrease by 16384 per sample to 0. tx_active falls on the edge that writes env=0; further outputs are 0.
- Reversal: drop tx_en at env=300 during RAMP_UP -> env decreases from 300 with no discontinuity. Re-raise tx_en at env=100 -> env increases from 100.
- Full-scale: ON, gain=255, data_in=-32768 -> data_out=-66846720. data_in=32767 -> data_out=66844680. No wrap.
- Reset mid-operation: pulse reset_n low at env=512 with two samples in flight -> no data_out_valid for those samples. Outputs are 0 and state is IDLE immediately.
